// File: rtl/sign_extend.sv
// Immediate sign extension: combinational result for the ALU/PC-offset path,
// plus a load-enabled registered copy with a sticky valid flag.
module sign_extend #(
    parameter int unsigned IN_WIDTH  = 2,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  Imm,
    input  logic                 load,
    output logic [OUT_WIDTH-1:0] Output,
    output logic [OUT_WIDTH-1:0] Output_q,
    output logic                 valid_q
);

    logic [OUT_WIDTH-1:0] ext;

    // Equal widths leave no room for extension bits, so that case passes Imm straight through.
    generate
        if (OUT_WIDTH > IN_WIDTH) begin : g_ext
            always_comb begin
                ext = {{(OUT_WIDTH-IN_WIDTH){Imm[IN_WIDTH-1]}}, Imm};
            end
        end else begin : g_pass
            always_comb begin
                ext = Imm;
            end
        end
    endgenerate

    always_comb begin
        Output = ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Output_q <= '0;
            valid_q  <= 1'b0;
        end else if (load) begin
            Output_q <= ext;
            valid_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Directed-vector bench for sign_extend at default widths and at 4->16.
`timescale 1ns/1ps
module tb_sign_extend;

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        load;
    logic [1:0]  imm;
    logic [7:0]  out8;
    logic [7:0]  out8_q;
    logic        valid8;
    logic [3:0]  imm4;
    logic [15:0] out16;
    logic [15:0] out16_q;
    logic        valid16;
    logic [2:0]  wide;

    int unsigned n_vec;
    int unsigned n_bad;

    sign_extend dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Imm      (imm),
        .load     (load),
        .Output   (out8),
        .Output_q (out8_q),
        .valid_q  (valid8)
    );

    sign_extend #(.IN_WIDTH(4), .OUT_WIDTH(16)) dut_wide (
        .clk      (clk),
        .rst_n    (rst_n),
        .Imm      (imm4),
        .load     (load),
        .Output   (out16),
        .Output_q (out16_q),
        .valid_q  (valid16)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        load   = 1'b0;
        imm    = 2'd0;
        imm4   = 4'b0000;

        // combinational sweep with the clock stopped
        #100 check("comb_imm0", 16'(out8), 16'h0000);
        imm = 2'd1; #100 check("comb_imm1", 16'(out8), 16'h0001);
        imm = 2'd2; #100 check("comb_imm2", 16'(out8), 16'h00FE);
        imm = 2'd3; #100 check("comb_imm3", 16'(out8), 16'h00FF);
        wide = 3'd4;
        imm  = 2'(wide);
        #100 check("trunc_4", 16'(out8), 16'h0000);

        check("rst_out_q", 16'(out8_q), 16'h0000);
        check("rst_valid", 16'(valid8), 16'h0000);

        imm4 = 4'b1000; #10 check("wide_neg", out16, 16'hFFF8);
        imm4 = 4'b0111; #10 check("wide_pos", out16, 16'h0007);

        // registered capture
        rst_n  = 1'b1;
        clk_en = 1'b1;
        @(negedge clk);
        imm  = 2'd2;
        imm4 = 4'b1000;
        load = 1'b1;
        @(posedge clk); #1;
        check("cap_out_q", 16'(out8_q), 16'h00FE);
        check("cap_valid", 16'(valid8), 16'h0001);
        check("wide_cap_q", out16_q, 16'hFFF8);
        @(negedge clk);
        load = 1'b0;
        imm  = 2'd1;
        repeat (3) @(posedge clk);
        #1;
        check("hold_out_q", 16'(out8_q), 16'h00FE);
        check("hold_valid", 16'(valid8), 16'h0001);
        check("hold_comb", 16'(out8), 16'h0001);

        // asynchronous reset mid-cycle, no clock edge involved
        @(posedge clk);
        #2;
        imm   = 2'd2;
        rst_n = 1'b0;
        #1;
        check("async_out_q", 16'(out8_q), 16'h0000);
        check("async_valid", 16'(valid8), 16'h0000);
        check("async_comb", 16'(out8), 16'h00FE);

        // reset wins over load across an edge
        imm  = 2'd3;
        load = 1'b1;
        @(posedge clk); #1;
        check("prio_out_q", 16'(out8_q), 16'h0000);
        check("prio_valid", 16'(valid8), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_q", 16'(out8_q), 16'h00FF);
        check("post_rst_v", 16'(valid8), 16'h0001);

        load   = 1'b0;
        clk_en = 1'b0;
        #20;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
